// File: rtl/fft_stage_sequencer_if.sv
// RAM, twiddle-ROM and butterfly connections of the FFT stage sequencer.
// Packed complex words: imag in the upper WIDTH/2 bits, real in the lower WIDTH/2 bits.
interface fft_stage_sequencer_if #(
    parameter int unsigned SAMPLES = 8,
    parameter int unsigned WIDTH   = 16
);
    localparam int unsigned LOG2N = $clog2(SAMPLES);
    localparam int unsigned TWA   = (LOG2N > 1) ? LOG2N - 1 : 1;

    logic             mem_rd_en;
    logic             mem_wr_en;
    logic [LOG2N-1:0] mem_addr_a;
    logic [LOG2N-1:0] mem_addr_b;
    logic [TWA-1:0]   tw_addr;
    logic [WIDTH-1:0] mem_rd_a;
    logic [WIDTH-1:0] mem_rd_b;
    logic [WIDTH-1:0] tw_data;
    logic [WIDTH-1:0] bf_in1;
    logic [WIDTH-1:0] bf_in2;
    logic [WIDTH-1:0] bf_tw;
    logic [WIDTH-1:0] bf_out1;
    logic [WIDTH-1:0] bf_out2;
    logic [WIDTH-1:0] mem_wr_a;
    logic [WIDTH-1:0] mem_wr_b;

    modport master (
        output mem_rd_en, mem_wr_en, mem_addr_a, mem_addr_b, tw_addr,
        output bf_in1, bf_in2, bf_tw, mem_wr_a, mem_wr_b,
        input  mem_rd_a, mem_rd_b, tw_data, bf_out1, bf_out2
    );

    modport slave (
        input  mem_rd_en, mem_wr_en, mem_addr_a, mem_addr_b, tw_addr,
        input  bf_in1, bf_in2, bf_tw, mem_wr_a, mem_wr_b,
        output mem_rd_a, mem_rd_b, tw_data, bf_out1, bf_out2
    );
endinterface

// File: rtl/fft_stage_sequencer.sv
// In-place radix-2 DIT FFT sequencer: walks stages/butterflies over a shared combinational
// butterfly, issuing RAM/twiddle addresses and writing results back (3 cycles per butterfly).
module fft_stage_sequencer #(
    parameter int unsigned SAMPLES = 8,
    parameter int unsigned WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    fft_stage_sequencer_if.master bus
);
    localparam int unsigned LOG2N = $clog2(SAMPLES);
    localparam int unsigned TWA   = (LOG2N > 1) ? LOG2N - 1 : 1;
    localparam int unsigned KW    = TWA;
    localparam int unsigned SW    = (LOG2N > 1) ? $clog2(LOG2N) : 1;

    localparam logic [KW-1:0] K_LAST = KW'(SAMPLES / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_CALC  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state_q,   state_d;
    logic [SW-1:0]    stage_q,   stage_d;
    logic [KW-1:0]    k_q,       k_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             rd_en_q,   rd_en_d;
    logic             wr_en_q,   wr_en_d;
    logic [LOG2N-1:0] addr_a_q,  addr_a_d;
    logic [LOG2N-1:0] addr_b_q,  addr_b_d;
    logic [TWA-1:0]   tw_addr_q, tw_addr_d;
    logic [WIDTH-1:0] wr_a_q,    wr_a_d;
    logic [WIDTH-1:0] wr_b_q,    wr_b_d;

    logic [LOG2N-1:0] half_v;
    logic [LOG2N-1:0] mask_v;
    logic [LOG2N-1:0] kx_v;
    logic [LOG2N-1:0] pos_v;
    logic [LOG2N-1:0] a_v;
    logic [SW-1:0]    tw_sh_v;

    // State sequencing, stage/butterfly counters and result capture.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        k_d     = k_q;
        wr_a_d  = wr_a_q;
        wr_b_d  = wr_b_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                state_d = S_CALC;
            end
            S_CALC: begin
                state_d = S_WRITE;
                wr_a_d  = bus.bf_out1;
                wr_b_d  = bus.bf_out2;
            end
            S_WRITE: begin
                state_d = S_READ;
                if (k_q == K_LAST) begin
                    k_d = '0;
                    if (stage_q == S_LAST) begin
                        state_d = S_DONE;
                        stage_d = '0;
                    end else begin
                        stage_d = stage_q + SW'(1);
                    end
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        rd_en_d = (state_d == S_READ);
        wr_en_d = (state_d == S_WRITE);
    end

    // Butterfly addressing for the upcoming (stage, k); zero outside an active butterfly.
    always_comb begin
        half_v  = LOG2N'(1) << stage_d;
        mask_v  = half_v - LOG2N'(1);
        kx_v    = LOG2N'(k_d);
        pos_v   = kx_v & mask_v;
        a_v     = ((kx_v & ~mask_v) << 1) | pos_v;
        tw_sh_v = S_LAST - stage_d;

        addr_a_d  = '0;
        addr_b_d  = '0;
        tw_addr_d = '0;
        if ((state_d == S_READ) || (state_d == S_CALC) || (state_d == S_WRITE)) begin
            addr_a_d  = a_v;
            addr_b_d  = a_v | half_v;
            tw_addr_d = TWA'(pos_v << tw_sh_v);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            stage_q   <= '0;
            k_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            addr_a_q  <= '0;
            addr_b_q  <= '0;
            tw_addr_q <= '0;
            wr_a_q    <= '0;
            wr_b_q    <= '0;
        end else begin
            state_q   <= state_d;
            stage_q   <= stage_d;
            k_q       <= k_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            addr_a_q  <= addr_a_d;
            addr_b_q  <= addr_b_d;
            tw_addr_q <= tw_addr_d;
            wr_a_q    <= wr_a_d;
            wr_b_q    <= wr_b_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign bus.mem_rd_en  = rd_en_q;
    assign bus.mem_wr_en  = wr_en_q;
    assign bus.mem_addr_a = addr_a_q;
    assign bus.mem_addr_b = addr_b_q;
    assign bus.tw_addr    = tw_addr_q;
    assign bus.mem_wr_a   = wr_a_q;
    assign bus.mem_wr_b   = wr_b_q;

    // Read data is only meaningful in CALC; the butterfly sees zeros otherwise.
    assign bus.bf_in1 = (state_q == S_CALC) ? bus.mem_rd_a : '0;
    assign bus.bf_in2 = (state_q == S_CALC) ? bus.mem_rd_b : '0;
    assign bus.bf_tw  = (state_q == S_CALC) ? bus.tw_data  : '0;
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: 8-point instance with RAM/ROM/butterfly models,
// plus a 2-point instance for the single-butterfly case.
module tb_fft_stage_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start8, start2;
    logic busy8, done8, busy2, done2;

    fft_stage_sequencer_if #(.SAMPLES(8), .WIDTH(16)) if8 ();
    fft_stage_sequencer_if #(.SAMPLES(2), .WIDTH(16)) if2 ();

    fft_stage_sequencer #(.SAMPLES(8), .WIDTH(16)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .busy(busy8), .done(done8), .bus(if8)
    );
    fft_stage_sequencer #(.SAMPLES(2), .WIDTH(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2), .bus(if2)
    );

    // Complex butterfly on 8-bit signed parts: returns {in1 - in2*w, in1 + in2*w}.
    function automatic logic [31:0] bfly(input logic [15:0] x1, input logic [15:0] x2,
                                         input logic [15:0] w);
        int ar, ai, br, bi, wr, wi, pr, pi;
        ar = int'($signed(x1[7:0]));
        ai = int'($signed(x1[15:8]));
        br = int'($signed(x2[7:0]));
        bi = int'($signed(x2[15:8]));
        wr = int'($signed(w[7:0]));
        wi = int'($signed(w[15:8]));
        pr = br * wr - bi * wi;
        pi = br * wi + bi * wr;
        return {8'(ai - pi), 8'(ar - pr), 8'(ai + pi), 8'(ar + pr)};
    endfunction

    // 8-word RAM with 1-cycle read latency, unity twiddle ROM, bench load port.
    logic [15:0] ram8 [8];
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;

    always_ff @(posedge clk) begin
        if (ld_en) begin
            ram8[ld_addr] <= ld_data;
        end else if (if8.mem_wr_en) begin
            ram8[if8.mem_addr_a] <= if8.mem_wr_a;
            ram8[if8.mem_addr_b] <= if8.mem_wr_b;
        end
        if (if8.mem_rd_en) begin
            if8.mem_rd_a <= ram8[if8.mem_addr_a];
            if8.mem_rd_b <= ram8[if8.mem_addr_b];
            if8.tw_data  <= 16'h0001;
        end
    end

    always_comb {if8.bf_out2, if8.bf_out1} = bfly(if8.bf_in1, if8.bf_in2, if8.bf_tw);

    assign if2.mem_rd_a = 16'h0003;
    assign if2.mem_rd_b = 16'h0001;
    assign if2.tw_data  = 16'h0001;
    assign {if2.bf_out2, if2.bf_out1} = bfly(if2.bf_in1, if2.bf_in2, if2.bf_tw);

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic [127:0] init;
        logic [127:0] exp;
    } vec_t;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
        logic [1:0] tw;
    } addr_t;

    vec_t  vecs  [4];
    addr_t exp_tr[12];
    addr_t tr    [12];
    logic [3:0] exp2 [5];
    logic       bp   [76];

    int nrd, nwr, nbusy, ndone, done_at, overlap, wr_mis;

    // Launch one 8-point transform and trace it; optionally poke start in READ, WRITE and DONE.
    task automatic run8(input bit poke);
        int cyc;
        nrd = 0; nwr = 0; nbusy = 0; ndone = 0; done_at = -1; overlap = 0; wr_mis = 0;
        @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        cyc = 0;
        while (busy8 && cyc < 200) begin
            nbusy++;
            if (if8.mem_rd_en && if8.mem_wr_en) overlap++;
            if (if8.mem_rd_en) begin
                if (nrd < 12) tr[nrd] = {if8.mem_addr_a, if8.mem_addr_b, if8.tw_addr};
                nrd++;
            end
            if (if8.mem_wr_en) begin
                if (nwr < 12 && tr[nwr] != {if8.mem_addr_a, if8.mem_addr_b, if8.tw_addr}) wr_mis++;
                nwr++;
            end
            if (done8) begin
                ndone++;
                done_at = nbusy;
            end
            start8 = poke && (cyc == 0 || cyc == 2 || cyc == 36);
            @(negedge clk);
            cyc++;
        end
        start8 = 1'b0;
        chk("run8_terminates", 32'(busy8), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd, bad;

        vecs[0].init = 128'h000A;
        vecs[0].exp  = {8{16'h000A}};
        vecs[1].init = {8{16'h0001}};
        vecs[1].exp  = 128'h0008;
        vecs[2].init = {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0003, 16'h0000};
        vecs[2].exp  = {4{16'h00FD, 16'h0003}};
        vecs[3].init = 128'h0500;
        vecs[3].exp  = {8{16'h0500}};

        exp_tr = '{'{3'd0, 3'd1, 2'd0}, '{3'd2, 3'd3, 2'd0}, '{3'd4, 3'd5, 2'd0}, '{3'd6, 3'd7, 2'd0},
                   '{3'd0, 3'd2, 2'd0}, '{3'd1, 3'd3, 2'd2}, '{3'd4, 3'd6, 2'd0}, '{3'd5, 3'd7, 2'd2},
                   '{3'd0, 3'd4, 2'd0}, '{3'd1, 3'd5, 2'd1}, '{3'd2, 3'd6, 2'd2}, '{3'd3, 3'd7, 2'd3}};
        exp2 = '{4'b1100, 4'b1000, 4'b1010, 4'b1001, 4'b0000};

        rst_n = 1'b0; start8 = 1'b0; start2 = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        repeat (3) @(negedge clk);

        chk("rst_busy8",  32'(busy8), 0);
        chk("rst_done8",  32'(done8), 0);
        chk("rst_strobe", 32'({if8.mem_rd_en, if8.mem_wr_en}), 0);
        chk("rst_addr",   32'({if8.mem_addr_a, if8.mem_addr_b, if8.tw_addr}), 0);
        chk("rst_wrdata", 32'({if8.mem_wr_a, if8.mem_wr_b}), 0);
        chk("rst_busy2",  32'(busy2), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset asserted mid-CALC aborts at once with no done pulse.
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        chk("t1_read_busy", 32'(busy8), 1);
        chk("t1_read_rden", 32'(if8.mem_rd_en), 1);
        @(negedge clk);
        chk("t1_calc_strobes", 32'({busy8, if8.mem_rd_en, if8.mem_wr_en}), 32'h4);
        rst_n = 1'b0;
        #1;
        chk("t1_abort_busy",    32'(busy8), 0);
        chk("t1_abort_strobes", 32'({if8.mem_rd_en, if8.mem_wr_en, done8}), 0);
        chk("t1_abort_addr",    32'({if8.mem_addr_a, if8.mem_addr_b, if8.tw_addr}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t1_no_done", 32'({busy8, done8}), 0);

        // Full pass: address trace, busy length, done pulse, no rd/wr overlap.
        run8(1'b0);
        chk("t3_busy_cycles", 32'(nbusy), 37);
        chk("t3_done_pulses", 32'(ndone), 1);
        chk("t3_done_last",   32'(done_at), 37);
        chk("t3_rdwr_overlap", 32'(overlap), 0);
        chk("t2_reads",       32'(nrd), 12);
        chk("t2_writes",      32'(nwr), 12);
        chk("t2_wr_addr_vs_rd", 32'(wr_mis), 0);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("t2_trace_%0d", i), 32'(tr[i]), 32'(exp_tr[i]));
        end

        // start pokes while busy are ignored.
        run8(1'b1);
        chk("t5_poke_busy_cycles", 32'(nbusy), 37);
        chk("t5_poke_done_pulses", 32'(ndone), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("t5_stays_idle_%0d", i), 32'(busy8), 0);
        end

        // Data vectors through the unity-twiddle butterfly.
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                ld_en   = 1'b1;
                ld_addr = 3'(i);
                ld_data = vecs[v].init[i*16 +: 16];
            end
            @(negedge clk);
            ld_en = 1'b0;
            run8(1'b0);
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("t4_vec%0d_ram%0d", v, i), 32'(ram8[i]), 32'(vecs[v].exp[i*16 +: 16]));
            end
        end

        // start held high: back-to-back runs separated by one IDLE cycle.
        @(negedge clk);
        start8 = 1'b1;
        nd = 0;
        for (int i = 0; i < 76; i++) begin
            @(negedge clk);
            bp[i] = busy8;
            if (done8) nd++;
        end
        start8 = 1'b0;
        bad = 0;
        for (int i = 0; i < 76; i++) begin
            if (bp[i] != ((i == 37 || i == 75) ? 1'b0 : 1'b1)) bad++;
        end
        chk("t5_held_busy_pattern", 32'(bad), 0);
        chk("t5_held_gap_idle",     32'(bp[37]), 0);
        chk("t5_held_done_count",   32'(nd), 2);
        repeat (2) @(negedge clk);
        chk("t5_held_release_idle", 32'(busy8), 0);

        // 2-point instance: READ, CALC, WRITE, DONE.
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("t6_ctl_c%0d", c),
                32'({busy2, if2.mem_rd_en, if2.mem_wr_en, done2}), 32'(exp2[c]));
            if (c < 3) begin
                chk($sformatf("t6_addr_c%0d", c),
                    32'({if2.mem_addr_a, if2.mem_addr_b, if2.tw_addr}), 32'h2);
            end
            if (c == 2) begin
                chk("t6_wr_a", 32'(if2.mem_wr_a), 32'h0004);
                chk("t6_wr_b", 32'(if2.mem_wr_b), 32'h0002);
            end
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
